imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
// Parametrised, pipelined immediate-extension unit for the ID stage of the MIPS pipeline.
// Extends an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, LUI, sign+shift-by-2.
// Carries a sideband tag through STAGES register slots with per-slot valid/ready flow control.
// Supports stall (back-pressure) and a branch-mispredict flush.
// PARAMETERS
// IN_W    16  immediate input width; must be >= 2
// OUT_W   32  extended output width; must be > IN_W
// STAGES  2   number of register slots, 1..4
// TAG_W   5   sideband tag width (e.g. dest register index), >= 1
// PORTS
// clk        in   1        clock, all state updates on rising edge
// rst_n      in   1        asynchronous, active-low reset
// flush      in   1        synchronous: invalidate every slot this cycle
// in_valid   in   1        input immediate valid
// in_ready   out  1        unit can accept this cycle
// in_imm     in   IN_W     raw immediate
// in_mode    in   2        00 SEXT, 01 ZEXT, 10 LUI, 11 SEXT_SHL2
// in_tag     in   TAG_W    sideband, passed through unchanged
// out_valid  out  1        out_imm/out_tag valid
// out_ready  in   1        downstream accepts this cycle
// out_imm    out  OUT_W    extended immediate
// out_tag    out  TAG_W    tag of the accepted item
// occupancy  out  3        number of valid slots, 0..STAGES
// BEHAVIOUR
// - Extension is combinational on the input side; result stored in slot 0:
//   SEXT: {(OUT_W-IN_W){imm[IN_W-1]}, imm}; ZEXT: {(OUT_W-IN_W){1'b0}, imm}
//   LUI: (imm << IN_W) truncated to OUT_W; low IN_W bits zero
//   SEXT_SHL2: SEXT result << 2, truncated to OUT_W; low 2 bits zero
// - Slots 0..STAGES-1, each holds {valid, imm, tag}; last slot drives out_*.
// - Slot i moves to slot i+1 when slot i valid and (slot i+1 empty or slot i+1 moving).
// - Last slot leaves when out_valid && out_ready. Bubbles collapse; no stage idles while data waits.
// - in_ready = slot 0 empty or slot 0 moving this cycle; accept = in_valid && in_ready.
// - Latency: item accepted at edge N appears on out_valid after edge N+STAGES-1 if no stall
//   (STAGES=1: visible the cycle after accept). Throughput one item/cycle when out_ready=1.
// - Order preserved; no item dropped or duplicated under any out_ready pattern.
// - out_imm/out_tag hold stable while out_valid=1 and out_ready=0.
// - occupancy = count of valid slots, registered, updated each edge.
// - flush: all valid bits cleared at the edge; an accept in the same cycle is discarded;
//   in_ready still reports per rule above; out_valid=0 next cycle; occupancy=0.
// - Reset (rst_n=0, any time, incl. mid-stream): all valid=0, out_imm=0, out_tag=0,
//   occupancy=0, in_ready=1 once rst_n=1 released; payload regs cleared to 0.
// - Only valid bits need reset semantics for function; payload reset to 0 for determinism.
// - in_mode not sampled when in_valid=0; unknown input values never propagate to valid outputs.
// TESTING
// T1 STAGES=2, SEXT 16'h8000 tag 5'd3, out_ready=1 -> out_imm 32'hFFFF8000, tag 3, 2 edges after accept
// T2 ZEXT 16'h8000 -> 32'h00008000; LUI 16'h1234 -> 32'h12340000; SEXT_SHL2 16'hFFFF -> 32'hFFFFFFFC
// T3 stream 6 items tags 0..5, out_ready=0 for 5 cycles -> exactly 2 accepted, in_ready=0,
//    occupancy=2, outputs stable; release -> tags 0..5 emerge in order, one per cycle
// T4 occupancy=2, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, item lost
// T5 rst_n low mid-stream for 1 cycle (async, between edges) -> out_valid=0, occupancy=0 immediately
// T6 sweep STAGES=1,4 and IN_W=8/OUT_W=16: SEXT 8'h80 -> 16'hFF80, latency equals STAGES, full throughput

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe_if
// Bundles the upstream (in_*) and downstream (out_*) handshakes of the
// immediate-extension pipe, plus its flush input and occupancy output.
//   flush      : invalidate every slot at the next edge
//   in_valid   : upstream offers in_imm/in_mode/in_tag
//   in_ready   : pipe accepts this cycle
//   in_imm     : raw immediate, IN_W bits
//   in_mode    : 00 SEXT, 01 ZEXT, 10 LUI, 11 SEXT_SHL2
//   in_tag     : sideband carried unchanged
//   out_valid  : out_imm/out_tag hold a valid item
//   out_ready  : downstream accepts this cycle
//   out_imm    : extended immediate, OUT_W bits
//   out_tag    : tag belonging to out_imm
//   occupancy  : number of valid slots
// master = producer/consumer side (e.g. the bench), slave = the pipe.
// ---------------------------------------------------------------------------
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       occupancy;

    modport master (
        output flush, in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, occupancy
    );

    modport slave (
        input  flush, in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, occupancy
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
// Pipelined immediate-extension unit for the ID stage. The immediate is
// extended combinationally on entry (SEXT, ZEXT, LUI, SEXT<<2) and the
// result travels with its tag through STAGES register slots. Every slot has
// its own valid bit and advances whenever the slot ahead is empty or is
// itself advancing, so bubbles collapse and a full pipe streams one item
// per cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : imm_extend_pipe_if.slave (handshakes, flush, occupancy)
// Parameters: IN_W >= 2, OUT_W > IN_W, STAGES 1..4, TAG_W >= 1.
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_extend_pipe_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_SEXT      = 2'b00,
        MODE_ZEXT      = 2'b01,
        MODE_LUI       = 2'b10,
        MODE_SEXT_SHL2 = 2'b11
    } mode_e;

    localparam int PAD_W = OUT_W - IN_W;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] move;      // slot i hands its item on at this edge
    logic [OUT_W-1:0]  imm_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [2:0]        occ_q;
    logic [2:0]        occ_d;
    logic              in_ready_c;
    logic              accept;
    logic [OUT_W-1:0]  sext_imm;
    logic [OUT_W-1:0]  ext_imm;

    // ------------------------------------------------------------------
    // Entry-side extension
    // ------------------------------------------------------------------
    always_comb begin : extend
        sext_imm = {{PAD_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
        // NOTE: assign a default before the case so every path drives
        // ext_imm; otherwise the tool infers a latch.
        ext_imm  = sext_imm;
        case (bus.in_mode)
            MODE_SEXT:      ext_imm = sext_imm;
            MODE_ZEXT:      ext_imm = {{PAD_W{1'b0}}, bus.in_imm};
            MODE_LUI:       ext_imm = {{PAD_W{1'b0}}, bus.in_imm} << IN_W;
            MODE_SEXT_SHL2: ext_imm = sext_imm << 2;
            default:        ext_imm = sext_imm;
        endcase
    end

    // ------------------------------------------------------------------
    // Flow control: resolve moves from the output end backwards, because a
    // full slot may advance only when the slot ahead is empty or leaving.
    // ------------------------------------------------------------------
    always_comb begin : flow
        move = '0;
        move[STAGES-1] = valid_q[STAGES-1] & bus.out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            move[i] = valid_q[i] & (~valid_q[i+1] | move[i+1]);
        end
    end

    assign in_ready_c = ~valid_q[0] | move[0];
    assign accept     = bus.in_valid & in_ready_c;

    // Next valid bits and the occupancy they imply. Flush overrides
    // everything, including an accept in the same cycle.
    always_comb begin : next_valid
        valid_d    = valid_q;
        occ_d      = '0;
        valid_d[0] = accept | (valid_q[0] & ~move[0]);
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = move[i-1] | (valid_q[i] & ~move[i]);
        end
        if (bus.flush) begin
            valid_d = '0;
        end
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + {2'b00, valid_d[i]};
        end
    end

    // ------------------------------------------------------------------
    // Slot registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so each slot
    // samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin : slots
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
            // NOTE: payload registers are reset too, only so outputs read
            // as zero after reset; the valid bits alone carry function.
            for (int i = 0; i < STAGES; i++) begin
                imm_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            if (accept) begin
                imm_q[0] <= ext_imm;
                tag_q[0] <= bus.in_tag;
            end
            // A stalled slot never loads, which keeps the output stable
            // while out_valid is high and out_ready is low.
            for (int i = 1; i < STAGES; i++) begin
                if (move[i-1]) begin
                    imm_q[i] <= imm_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_imm   = imm_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];
    assign bus.occupancy = occ_q;
endmodule
